pwm_peripheral: RTL and testbench

// - Downstream consumer of the SPI register file: turns the five config registers into 16 registered outputs.
// - Each channel is forced low, driven static high, or driven by one shared 8-bit PWM waveform.
// - The waveform period is 256 prescaled ticks; at CLK_DIV=13 and clk=10 MHz that is about 3.0 kHz.
// - Duty is double-buffered so an SPI write never produces a runt or truncated pulse.

---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_prescaler.sv | 32 +++
 rtl/pwm_peripheral.sv | 74 +++++++
 tb/tb_pwm_peripheral.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, types and the duty compare for the 16-channel PWM peripheral.
package pwm_pkg;

  localparam int unsigned NUM_CH    = 16;
  localparam int unsigned PWM_CNT_W = 8;

  localparam logic [PWM_CNT_W-1:0] DUTY_FULL = 8'hFF;

  typedef logic [PWM_CNT_W-1:0] pwm_cnt_t;

  // Per-channel enable and mode masks, channel 15 in the MSB
  typedef struct packed {
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] en_pwm;
  } ch_cfg_t;

  // Full-scale duty saturates to always-high instead of 255/256
  function automatic logic pwm_level(input pwm_cnt_t cnt, input pwm_cnt_t duty);
    return (duty == DUTY_FULL) || (cnt < duty);
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV clocks.
module pwm_prescaler
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  // With CLK_DIV=1 the counter is pinned at 0 and tick stays high
  always_comb begin
    tick   = (pcnt_q == PCNT_LAST);
    pcnt_d = tick ? '0 : pcnt_q + PCNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// Turns the SPI config registers into 16 registered outputs: off, static high,
// or one shared 8-bit PWM waveform with duty double-buffered at each period start.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);

  logic              tick;
  logic              pcnt_zero_q, pcnt_zero_d;
  pwm_cnt_t          cnt_q, cnt_d;
  pwm_cnt_t          duty_sh_q, duty_sh_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic              period_start_q, period_start_d;
  ch_cfg_t           cfg;
  logic              start_c;
  logic              pwm_raw;

  pwm_prescaler #(
    .CLK_DIV (CLK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // pcnt wraps to 0 right after a tick, so a registered tick marks pcnt==0
  always_comb begin
    cfg.en_out     = {en_reg_out_15_8, en_reg_out_7_0};
    cfg.en_pwm     = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    start_c        = pcnt_zero_q && (cnt_q == '0);
    pcnt_zero_d    = tick;
    cnt_d          = tick ? cnt_q + PWM_CNT_W'(1) : cnt_q;
    duty_sh_d      = start_c ? pwm_duty_cycle : duty_sh_q;
    period_start_d = start_c;
    // Compare against the duty in effect this cycle so the captured value
    // already governs the first clk of its own period
    pwm_raw        = pwm_level(cnt_q, duty_sh_d);
    out_d          = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_d[i] = cfg.en_out[i] & (cfg.en_pwm[i] ? pwm_raw : 1'b1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_zero_q    <= 1'b1;
      cnt_q          <= '0;
      duty_sh_q      <= '0;
      out_q          <= '0;
      period_start_q <= 1'b0;
    end else begin
      pcnt_zero_q    <= pcnt_zero_d;
      cnt_q          <= cnt_d;
      duty_sh_q      <= duty_sh_d;
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral at CLK_DIV=13: reset, static enables,
// PWM duty extremes, mid-period duty update and asynchronous reset mid-pulse.
module tb_pwm_peripheral;

  localparam int PERIOD = 3328;

  logic        clk;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0;
  logic [7:0]  en_reg_out_15_8;
  logic [7:0]  en_reg_pwm_7_0;
  logic [7:0]  en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out_s;
  logic        ps_s;

  int n_cmp = 0;
  int n_err = 0;

  pwm_peripheral #(
    .CLK_DIV (13)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out_s),
    .period_start    (ps_s)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp_v, exp_v);
    end
  endtask

  task automatic wait_ps(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ps_s && k < 4000);
    check_eq(tag, int'(ps_s), 1);
  endtask

  // Samples n negedges starting at the current one, then steps to the next
  task automatic measure(input int n, input int wr_at, input logic [7:0] wr_val,
                         output int hi, output int last_hi, output int trans,
                         output int ps, output int other, output int next_ps);
    logic prev;
    hi = 0; last_hi = -1; trans = 0; ps = 0; other = 0;
    prev = out_s[3];
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      if (out_s[3]) begin
        hi++;
        last_hi = i;
      end
      if (i > 0 && out_s[3] != prev) trans++;
      prev = out_s[3];
      if (ps_s) ps++;
      if ((out_s & ~16'h0008) != 16'h0000) other++;
      if (i == wr_at) pwm_duty_cycle = wr_val;
    end
    @(negedge clk);
    next_ps = int'(ps_s);
  endtask

  task automatic run_window(input string tag, input int n, input int wr_at,
                            input logic [7:0] wr_val, input int e_hi,
                            input int e_last, input int e_trans, input int e_ps);
    int hi, last_hi, trans, ps, other, next_ps;
    measure(n, wr_at, wr_val, hi, last_hi, trans, ps, other, next_ps);
    check_eq({tag, "_high"},    hi,      e_hi);
    check_eq({tag, "_lasthi"},  last_hi, e_last);
    check_eq({tag, "_edges"},   trans,   e_trans);
    check_eq({tag, "_ps"},      ps,      e_ps);
    check_eq({tag, "_others"},  other,   0);
    check_eq({tag, "_next_ps"}, next_ps, 1);
  endtask

  initial begin
    int nz;
    rst_n           = 1'b0;
    en_reg_out_7_0  = 8'hFF;
    en_reg_out_15_8 = 8'hFF;
    en_reg_pwm_7_0  = 8'hFF;
    en_reg_pwm_15_8 = 8'hFF;
    pwm_duty_cycle  = 8'hFF;

    repeat (3) @(negedge clk);
    check_eq("rst_out", int'(out_s), 0);
    check_eq("rst_ps",  int'(ps_s),  0);

    en_reg_out_7_0  = 8'h00;
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_7_0  = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    pwm_duty_cycle  = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_ps",  int'(ps_s),  1);
    check_eq("rel_out", int'(out_s), 0);
    nz = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_s != 16'h0000) nz++;
    end
    check_eq("rel_quiet", nz, 0);

    // Static-high path and the high-byte concatenation
    en_reg_out_7_0 = 8'h01;
    check_eq("st_pre", int'(out_s), 0);
    @(negedge clk);
    check_eq("st_ch0_on", int'(out_s), 32'h0001);
    en_reg_out_7_0 = 8'h00;
    @(negedge clk);
    check_eq("st_ch0_off", int'(out_s), 0);
    en_reg_out_15_8 = 8'h80;
    @(negedge clk);
    check_eq("st_ch15_on", int'(out_s), 32'h8000);
    en_reg_pwm_15_8 = 8'h80;
    @(negedge clk);
    check_eq("st_ch15_pwm0", int'(out_s), 0);
    en_reg_out_15_8 = 8'h00;
    en_reg_pwm_15_8 = 8'h00;
    @(negedge clk);
    check_eq("st_all_off", int'(out_s), 0);

    // 50% duty on channel 3: 128 ticks * 13 clk high per 3328-clk period
    pwm_duty_cycle = 8'h80;
    en_reg_out_7_0 = 8'h08;
    en_reg_pwm_7_0 = 8'h08;
    wait_ps("w_p50");
    run_window("p50", PERIOD, -1, 8'h00, 1664, 1663, 1, 1);

    pwm_duty_cycle = 8'h00;
    wait_ps("w_d00");
    run_window("d00", 2 * PERIOD, -1, 8'h00, 0, -1, 0, 2);

    pwm_duty_cycle = 8'hFF;
    wait_ps("w_dff");
    run_window("dff", 2 * PERIOD, -1, 8'h00, 2 * PERIOD, 2 * PERIOD - 1, 0, 2);

    // 0x40 -> 0xC0 written at cnt=0x10: 64 ticks now, 192 ticks next period
    pwm_duty_cycle = 8'h40;
    wait_ps("w_mid");
    run_window("mid_cur",  PERIOD, 208, 8'hC0, 832, 831, 1, 1);
    run_window("mid_next", PERIOD, -1, 8'h00, 2496, 2495, 1, 1);

    // Asynchronous reset in the middle of a 50% pulse
    pwm_duty_cycle = 8'h80;
    wait_ps("w_rst");
    repeat (416) @(negedge clk);
    check_eq("rst_mid_hi", int'(out_s[3]), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_async_out", int'(out_s), 0);
    check_eq("rst_async_ps",  int'(ps_s),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_ps", int'(ps_s), 1);
    run_window("rst_p50", PERIOD, -1, 8'h00, 1664, 1663, 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
